// File: rtl/parity_frame_controller.sv
// parity_frame_controller
//   Receives a serial frame of DATA_BITS data bits, LSB first, followed by
//   one parity bit. It compares the received parity bit against the parity
//   it computed itself and reports the result.
//
// Parameters
//   DATA_BITS  : data bits per frame, 1..255
//   ODD_PARITY : 0 = even parity, 1 = odd parity
//
// Ports
//   clk, reset  : rising-edge clock, synchronous active-high reset
//   start       : begins a frame; accepted in IDLE only
//   abort       : discards the frame in progress (DATA or PARITY state)
//   x, x_valid  : serial bit, consumed on any edge where x_valid=1
//   busy        : state is not IDLE
//   done        : one-cycle pulse while in REPORT
//   parity_err  : result of the last completed frame
//   parity      : running parity of the data bits accepted so far
//   bit_count   : data bits accepted in the current frame
//   err_count   : number of failed frames, saturating at 255
//
// Handshake: x is taken on a rising edge only when x_valid=1 and the FSM is
// in DATA or PARITY. There is no back-pressure; the sender must not present
// bits while the block is in IDLE or REPORT, because they are ignored.
module parity_frame_controller #(
  parameter int DATA_BITS  = 8,
  parameter int ODD_PARITY = 0
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic       abort,
  input  logic       x,
  input  logic       x_valid,
  output logic       busy,
  output logic       done,
  output logic       parity_err,
  output logic       parity,
  output logic [7:0] bit_count,
  output logic [7:0] err_count
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_DATA   = 2'd1,
    S_PARITY = 2'd2,
    S_REPORT = 2'd3
  } state_t;

  localparam logic [7:0] LAST_BIT   = 8'(DATA_BITS - 1);
  localparam logic       PARITY_INIT = (ODD_PARITY != 0);

  state_t     state_q, state_d;
  logic       parity_q, parity_d;
  logic       parity_err_q, parity_err_d;
  logic [7:0] bit_count_q, bit_count_d;
  logic [7:0] err_count_q, err_count_d;

  always_comb begin
    state_d      = state_q;
    parity_d     = parity_q;
    parity_err_d = parity_err_q;
    bit_count_d  = bit_count_q;
    err_count_d  = err_count_q;

    case (state_q)
      S_IDLE: begin
        // x/x_valid in the start cycle are deliberately not consumed.
        if (start) begin
          state_d     = S_DATA;
          parity_d    = PARITY_INIT;
          bit_count_d = 8'd0;
        end
      end

      S_DATA: begin
        // abort wins over a coincident data bit.
        if (abort) begin
          state_d = S_IDLE;
        end else if (x_valid) begin
          parity_d    = parity_q ^ x;
          bit_count_d = bit_count_q + 8'd1;
          if (bit_count_q == LAST_BIT) begin
            state_d = S_PARITY;
          end
        end
      end

      S_PARITY: begin
        // abort wins over a coincident parity bit.
        if (abort) begin
          state_d = S_IDLE;
        end else if (x_valid) begin
          state_d      = S_REPORT;
          parity_err_d = (x != parity_q);
          if ((x != parity_q) && (err_count_q != 8'hFF)) begin
            err_count_d = err_count_q + 8'd1;
          end
        end
      end

      S_REPORT: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= S_IDLE;
      parity_q     <= 1'b0;
      parity_err_q <= 1'b0;
      bit_count_q  <= 8'd0;
      err_count_q  <= 8'd0;
    end else begin
      state_q      <= state_d;
      parity_q     <= parity_d;
      parity_err_q <= parity_err_d;
      bit_count_q  <= bit_count_d;
      err_count_q  <= err_count_d;
    end
  end

  assign busy       = (state_q != S_IDLE);
  assign done       = (state_q == S_REPORT);
  assign parity_err = parity_err_q;
  assign parity     = parity_q;
  assign bit_count  = bit_count_q;
  assign err_count  = err_count_q;

endmodule

// File: tb/tb_parity_frame_controller.sv
// Bench for parity_frame_controller (DATA_BITS=8): an even-parity instance
// with a scoreboard, plus an odd-parity instance driven with a short
// directed sequence. Inputs change and outputs are sampled on the falling
// edge; the DUT acts on the rising edge.
module tb_parity_frame_controller;

  // ---------------------------------------------------------------- clock/reset
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  // even-parity DUT
  logic       start, abort, x, x_valid;
  logic       busy, done, parity_err, parity;
  logic [7:0] bit_count, err_count;

  parity_frame_controller #(.DATA_BITS(8), .ODD_PARITY(0)) u_dut (
    .clk(clk), .reset(reset), .start(start), .abort(abort), .x(x),
    .x_valid(x_valid), .busy(busy), .done(done), .parity_err(parity_err),
    .parity(parity), .bit_count(bit_count), .err_count(err_count)
  );

  // odd-parity DUT
  logic       o_start, o_abort, o_x, o_x_valid;
  logic       o_busy, o_done, o_parity_err, o_parity;
  logic [7:0] o_bit_count, o_err_count;

  parity_frame_controller #(.DATA_BITS(8), .ODD_PARITY(1)) u_odd (
    .clk(clk), .reset(reset), .start(o_start), .abort(o_abort), .x(o_x),
    .x_valid(o_x_valid), .busy(o_busy), .done(o_done),
    .parity_err(o_parity_err), .parity(o_parity),
    .bit_count(o_bit_count), .err_count(o_err_count)
  );

  // ---------------------------------------------------------------- bookkeeping
  int n_checks = 0;
  int n_fail   = 0;
  logic [8:0] exp_q[$];          // {parity_err, err_count} per frame
  logic [7:0] model_err_count;

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------- monitor
  always @(negedge clk) begin
    if (!reset && done) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_done: got done=1 expected no frame at %0t", $time);
      end else begin
        logic [8:0] e;
        e = exp_q.pop_front();
        check("sb_parity_err", {31'd0, parity_err}, {31'd0, e[8]});
        check("sb_err_count", {24'd0, err_count}, {24'd0, e[7:0]});
      end
    end
  end

  // ---------------------------------------------------------------- drivers
  task automatic wait_idle();
    int n;
    n = 0;
    while (busy && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("wait_idle_timeout", {31'd0, busy}, 32'd0);
  endtask

  // Sends a whole frame: start, 8 data bits (gap idle cycles before each),
  // then the parity bit. poke_start raises start during the gaps.
  task automatic send_frame(input logic [7:0] d, input logic pbit,
                            input int gap, input logic poke_start);
    logic run_par;
    logic exp_err;
    run_par = 1'b0;
    @(negedge clk);
    start = 1'b1; x_valid = 1'b1; x = 1'b1;   // must be ignored
    @(negedge clk);
    start = 1'b0; x_valid = 1'b0;
    check("start_bit_count", {24'd0, bit_count}, 32'd0);
    check("start_busy", {31'd0, busy}, 32'd1);
    for (int i = 0; i < 8; i++) begin
      for (int g = 0; g < gap; g++) begin
        start = poke_start;
        @(negedge clk);
        start = 1'b0;
        check("gap_bit_count", {24'd0, bit_count}, i);
      end
      x_valid = 1'b1; x = d[i];
      @(negedge clk);
      x_valid = 1'b0;
      run_par = run_par ^ d[i];
      check("data_bit_count", {24'd0, bit_count}, i + 1);
      check("data_parity", {31'd0, parity}, {31'd0, run_par});
    end
    exp_err = (pbit != run_par);
    if (exp_err && model_err_count != 8'hFF) model_err_count++;
    exp_q.push_back({exp_err, model_err_count});
    x_valid = 1'b1; x = pbit;
    @(negedge clk);
    x_valid = 1'b0;
    check("done_latency", {31'd0, done}, 32'd1);
    @(negedge clk);
    check("done_one_cycle", {31'd0, done}, 32'd0);
    check("back_idle", {31'd0, busy}, 32'd0);
  endtask

  // Drives n data bits of d (no gaps) after a start; leaves FSM mid-frame.
  task automatic partial_frame(input logic [7:0] d, input int n);
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < n; i++) begin
      x_valid = 1'b1; x = d[i];
      @(negedge clk);
    end
    x_valid = 1'b0;
  endtask

  // ---------------------------------------------------------------- stimulus
  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    logic [7:0] saved_err;
    reset = 1'b1; start = 1'b0; abort = 1'b0; x = 1'b0; x_valid = 1'b0;
    o_start = 1'b0; o_abort = 1'b0; o_x = 1'b0; o_x_valid = 1'b0;
    model_err_count = 8'd0;
    // reset overrides start/x_valid
    @(negedge clk); start = 1'b1; x_valid = 1'b1; abort = 1'b1;
    @(negedge clk); @(negedge clk);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_parity_err", {31'd0, parity_err}, 32'd0);
    check("rst_parity", {31'd0, parity}, 32'd0);
    check("rst_bit_count", {24'd0, bit_count}, 32'd0);
    check("rst_err_count", {24'd0, err_count}, 32'd0);
    start = 1'b0; x_valid = 1'b0; abort = 1'b0;
    reset = 1'b0;
    @(negedge clk);

    // good frame 0xB2 (four ones), parity 0
    send_frame(8'hB2, 1'b0, 0, 1'b0);
    // bad frame, then good frame; err_count stays 1
    send_frame(8'hB2, 1'b1, 0, 1'b0);
    check("err_after_bad", {24'd0, err_count}, 32'd1);
    send_frame(8'hB2, 1'b0, 0, 1'b0);
    check("err_after_good", {31'd0, parity_err}, 32'd0);
    // gaps of 3 idle cycles with start poked during the gaps
    send_frame(8'hB2, 1'b0, 3, 1'b1);
    send_frame(8'h01, 1'b1, 1, 1'b0);
    send_frame(8'hFF, 1'b0, 0, 1'b0);

    // abort after 4 data bits
    saved_err = model_err_count;
    partial_frame(8'hB2, 4);
    check("pre_abort_bit_count", {24'd0, bit_count}, 32'd4);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    check("abort_busy", {31'd0, busy}, 32'd0);
    check("abort_done", {31'd0, done}, 32'd0);
    check("abort_err_count", {24'd0, err_count}, {24'd0, saved_err});
    // abort coincident with the final data bit
    partial_frame(8'hB2, 7);
    abort = 1'b1; x_valid = 1'b1; x = 1'b1;
    @(negedge clk);
    abort = 1'b0; x_valid = 1'b0;
    check("abort_last_data_busy", {31'd0, busy}, 32'd0);
    // abort coincident with a bad parity bit
    partial_frame(8'hB2, 8);
    abort = 1'b1; x_valid = 1'b1; x = 1'b1;
    @(negedge clk);
    abort = 1'b0; x_valid = 1'b0;
    check("abort_par_busy", {31'd0, busy}, 32'd0);
    check("abort_par_done", {31'd0, done}, 32'd0);
    @(negedge clk);
    check("abort_par_err_count", {24'd0, err_count}, {24'd0, saved_err});
    check("abort_par_parity_err", {31'd0, parity_err}, 32'd0);
    // abort in IDLE has no effect on a following start
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    check("abort_idle_busy", {31'd0, busy}, 32'd0);

    // bad frame, then reset while in PARITY
    send_frame(8'h0F, 1'b1, 0, 1'b0);
    partial_frame(8'hB2, 8);
    check("in_parity_busy", {31'd0, busy}, 32'd1);
    reset = 1'b1; x_valid = 1'b1; x = 1'b1;
    @(negedge clk);
    reset = 1'b0; x_valid = 1'b0;
    model_err_count = 8'd0;
    check("mid_rst_busy", {31'd0, busy}, 32'd0);
    check("mid_rst_done", {31'd0, done}, 32'd0);
    check("mid_rst_parity_err", {31'd0, parity_err}, 32'd0);
    check("mid_rst_parity", {31'd0, parity}, 32'd0);
    check("mid_rst_bit_count", {24'd0, bit_count}, 32'd0);
    check("mid_rst_err_count", {24'd0, err_count}, 32'd0);

    // saturation: 257 bad frames
    for (int k = 0; k < 257; k++) begin
      send_frame(8'(k), ~(^8'(k)), 0, 1'b0);
    end
    check("sat_err_count", {24'd0, err_count}, 32'd255);
    send_frame(8'h3C, 1'b0, 0, 1'b0);
    check("sat_hold_good", {24'd0, err_count}, 32'd255);
    wait_idle();

    // odd parity: 0x00 with parity 1 is good, with parity 0 is bad
    for (int f = 0; f < 2; f++) begin
      @(negedge clk);
      o_start = 1'b1;
      @(negedge clk);
      o_start = 1'b0;
      check("odd_init_parity", {31'd0, o_parity}, 32'd1);
      for (int i = 0; i < 8; i++) begin
        o_x_valid = 1'b1; o_x = 1'b0;
        @(negedge clk);
      end
      o_x = (f == 0);
      @(negedge clk);
      o_x_valid = 1'b0;
      check("odd_done", {31'd0, o_done}, 32'd1);
      check("odd_parity_err", {31'd0, o_parity_err}, (f == 0) ? 32'd0 : 32'd1);
      check("odd_err_count", {24'd0, o_err_count}, (f == 0) ? 32'd0 : 32'd1);
      @(negedge clk);
    end

    @(negedge clk);
    check("sb_drained", exp_q.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/parity_frame_controller.md
PARITY_FRAME_CONTROLLER -- requirements
Module: parity_frame_controller

Interface
REQ-001 The block SHALL have parameter DATA_BITS, default 8, meaning the number of serial data bits per frame (legal range 1..255).
REQ-002 The block SHALL have parameter ODD_PARITY, default 0, where 0 selects even parity and 1 selects odd parity.
REQ-003 The block SHALL have one clock and a synchronous active-high reset: clk  in  1  rising-edge clock; reset  in  1  synchronous, active-high.
REQ-004 Ports SHALL be, one per line:
- start  in  1  begin a frame; accepted in IDLE only
- abort  in  1  discard the current frame
- x  in  1  serial bit, LSB first; the final bit of each frame is the parity bit
- x_valid  in  1  x is consumed on this edge
- busy  out  1  high when state is not IDLE
- done  out  1  one-cycle pulse when a frame has been checked
- parity_err  out  1  result of the last completed frame
- parity  out  1  running parity of the data bits accepted so far
- bit_count  out  8  data bits accepted in the current frame
- err_count  out  8  number of frames that failed, saturating

Function
REQ-005 The FSM SHALL have states IDLE, DATA, PARITY and REPORT, all transitions on the rising edge of clk.
REQ-006 In IDLE with start=1, the FSM SHALL go to DATA and clear parity to ODD_PARITY and bit_count to 0; x/x_valid in the same cycle SHALL be ignored.
REQ-007 In DATA with x_valid=1, the block SHALL update parity to parity XOR x and increment bit_count; with x_valid=0 it SHALL hold all state.
REQ-008 In DATA, when x_valid=1 and bit_count=DATA_BITS-1, the FSM SHALL go to PARITY (bit_count reaches DATA_BITS).
REQ-009 In PARITY with x_valid=1, the FSM SHALL register parity_err = (x != parity) and go to REPORT.
REQ-010 In PARITY with x_valid=0, the FSM SHALL wait indefinitely.
REQ-011 In REPORT, done SHALL be 1 for exactly one cycle, and the FSM SHALL return to IDLE on the next edge.
REQ-012 On entry to REPORT with parity_err=1, err_count SHALL increment, saturating at 255.
REQ-013 parity_err SHALL hold its value until the next REPORT or reset; start SHALL NOT clear it.
REQ-014 start SHALL be ignored while busy=1, including in REPORT.
REQ-015 abort=1 in DATA or PARITY SHALL return the FSM to IDLE on the next edge, with no done pulse and no change to parity_err or err_count.
REQ-016 abort SHALL win over a simultaneous final data bit or parity bit.
REQ-017 abort in IDLE or REPORT SHALL have no effect.
REQ-018 Combinational latency SHALL be: parity bit accepted at edge N, done=1 during cycle N+1; busy is registered from state.
REQ-019 Minimum frame time SHALL be DATA_BITS+3 cycles from the start edge back to IDLE.

Reset
REQ-020 With reset=1 at a rising edge, the block SHALL set state=IDLE, busy=0, done=0, parity_err=0, parity=0, bit_count=0 and err_count=0.
REQ-021 Reset SHALL override start, abort and x_valid.
REQ-022 Reset mid-frame SHALL discard the frame without a done pulse.
REQ-023 All outputs SHALL be driven from registers or state decode, with no combinational path from inputs to outputs.

Verification
REQ-024 Even parity, DATA_BITS=8: start, then data bits 0,1,0,0,1,1,0,1 (0xB2) with x_valid=1 each cycle, then parity bit 0 -> done pulse at cycle 11, parity_err=0, err_count=0.
REQ-025 Same frame with parity bit 1 -> parity_err=1 and err_count=1; the next good frame -> parity_err=0 and err_count stays 1.
REQ-026 0xB2 sent with x_valid=0 gaps of 3 cycles between bits -> same result as REQ-024; bit_count advances only on valid bits; start pulsed mid-frame has no effect.
REQ-027 abort after 4 data bits -> busy=0 the next cycle, no done pulse, err_count unchanged; abort coincident with the parity bit -> no done pulse.
REQ-028 Reset asserted in PARITY -> all outputs at reset values the next cycle; 256 consecutive bad frames -> err_count=255 and held.
REQ-029 ODD_PARITY=1 with data 0x00 and parity bit 1 -> parity_err=0.
